// File: rtl/max_pool_pkg.sv
// max_pool_pkg: shared defaults, element type and MIN helper for the max-pooling unit
package max_pool_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_SA_LENGTH = 10;
  localparam int DEF_MAX_FILTER_SIZE = 7;
  typedef logic signed [DEF_DATA_WIDTH-1:0] elem_t;
  function automatic logic signed [63:0] min_of(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction
endpackage

// File: rtl/max2.sv
// max2: combinational signed maximum; ports a, b in, y = max(a, b) out
module max2
  import max_pool_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] y
);
  assign y = (a > b) ? a : b;
endmodule

// File: rtl/vmax_calculator.sv
// vmax_calculator: per-lane running max over the newest 1..MAX_FILTER_SIZE rows
// ports: clk, rst (sync high), clear (history flush), in_valid/HMax row in, out_valid/VMaxs registered maxima out
module vmax_calculator
  import max_pool_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SA_LENGTH = DEF_SA_LENGTH,
  parameter int MAX_FILTER_SIZE = DEF_MAX_FILTER_SIZE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] HMax  [SA_LENGTH],
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] VMaxs [MAX_FILTER_SIZE][SA_LENGTH]
);
  localparam logic signed [DATA_WIDTH-1:0] MIN = DATA_WIDTH'(min_of(DATA_WIDTH));
  logic signed [DATA_WIDTH-1:0] m       [MAX_FILTER_SIZE][SA_LENGTH];
  logic signed [DATA_WIDTH-1:0] vmaxs_d [MAX_FILTER_SIZE][SA_LENGTH];
  logic signed [DATA_WIDTH-1:0] vmaxs_q [MAX_FILTER_SIZE][SA_LENGTH];
  logic out_valid_d, out_valid_q;
  for (genvar i = 0; i < SA_LENGTH; i++) begin : g_lane
    assign m[0][i] = HMax[i];
  end
  if (MAX_FILTER_SIZE > 1) begin : g_hist
    localparam int HD = MAX_FILTER_SIZE - 1;
    logic signed [DATA_WIDTH-1:0] hist_d [HD][SA_LENGTH];
    logic signed [DATA_WIDTH-1:0] hist_q [HD][SA_LENGTH];
    logic signed [DATA_WIDTH-1:0] hv     [HD][SA_LENGTH];
    // hv is the history as seen this cycle: a clear makes it empty immediately
    always_comb begin
      for (int k = 0; k < HD; k++)
        for (int i = 0; i < SA_LENGTH; i++)
          hv[k][i] = clear ? MIN : hist_q[k][i];
    end
    always_comb begin
      for (int i = 0; i < SA_LENGTH; i++) begin
        hist_d[0][i] = in_valid ? HMax[i] : hv[0][i];
        for (int k = 1; k < HD; k++)
          hist_d[k][i] = in_valid ? hv[k-1][i] : hv[k][i];
      end
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < HD; k++)
          for (int i = 0; i < SA_LENGTH; i++)
            hist_q[k][i] <= MIN;
      end else begin
        hist_q <= hist_d;
      end
    end
    for (genvar k = 1; k < MAX_FILTER_SIZE; k++) begin : g_stage
      for (genvar i = 0; i < SA_LENGTH; i++) begin : g_col
        max2 #(.DATA_WIDTH(DATA_WIDTH)) u_max2 (
          .a(m[k-1][i]),
          .b(hv[k-1][i]),
          .y(m[k][i])
        );
      end
    end
  end
  always_comb begin
    out_valid_d = in_valid;
    for (int k = 0; k < MAX_FILTER_SIZE; k++)
      for (int i = 0; i < SA_LENGTH; i++)
        vmaxs_d[k][i] = in_valid ? m[k][i] : vmaxs_q[k][i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      for (int k = 0; k < MAX_FILTER_SIZE; k++)
        for (int i = 0; i < SA_LENGTH; i++)
          vmaxs_q[k][i] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      vmaxs_q <= vmaxs_d;
    end
  end
  assign out_valid = out_valid_q;
  assign VMaxs = vmaxs_q;
endmodule

// File: tb/tb_vmax_calculator.sv
// tb_vmax_calculator: directed self-checking bench for vmax_calculator
module tb_vmax_calculator;
  localparam int DW = 32;
  localparam int SL = 10;
  localparam int MF = 7;
  localparam logic signed [DW-1:0] MINV = 32'sh8000_0000;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic signed [DW-1:0] hmax [SL];
  logic out_valid;
  logic signed [DW-1:0] vmaxs [MF][SL];
  int n_checks = 0;
  int n_fail = 0;
  vmax_calculator #(.DATA_WIDTH(DW), .SA_LENGTH(SL), .MAX_FILTER_SIZE(MF)) dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .in_valid(in_valid),
    .HMax(hmax),
    .out_valid(out_valid),
    .VMaxs(vmaxs)
  );
  always #5 clk = ~clk;
  task automatic cyc(input bit v, input bit c, input bit r);
    in_valid = v;
    clear = c;
    rst = r;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear = 1'b0;
    rst = 1'b0;
  endtask
  task automatic row(input int l, input logic signed [DW-1:0] val, input bit c);
    for (int i = 0; i < SL; i++) hmax[i] = '0;
    hmax[l] = val;
    cyc(1'b1, c, 1'b0);
  endtask
  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b1);
  endtask
  task automatic test_reset();
    logic signed [DW-1:0] vec [SL];
    vec = '{642, 905, 248, 834, 419, 978, 710, 105, 372, 587};
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    for (int k = 0; k < MF; k++)
      for (int i = 0; i < SL; i++) begin
        n_checks++;
        if (vmaxs[k][i] !== 0) begin n_fail++; $display("FAIL reset_vmaxs[%0d][%0d] got %0d exp 0", k, i, vmaxs[k][i]); end
      end
    hmax = vec;
    cyc(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_out_valid got %b exp 1", out_valid); end
    for (int k = 0; k < MF; k++)
      for (int i = 0; i < SL; i++) begin
        n_checks++;
        if (vmaxs[k][i] !== vec[i]) begin n_fail++; $display("FAIL first_row[%0d][%0d] got %0d exp %0d", k, i, vmaxs[k][i], vec[i]); end
      end
    cyc(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pulse_out_valid got %b exp 0", out_valid); end
  endtask
  task automatic test_sliding();
    do_reset();
    row(0, 642, 1'b0);
    row(0, 100, 1'b0);
    row(0, -5, 1'b0);
    n_checks++;
    if (vmaxs[0][0] !== -5) begin n_fail++; $display("FAIL slide_k0 got %0d exp -5", vmaxs[0][0]); end
    n_checks++;
    if (vmaxs[1][0] !== 100) begin n_fail++; $display("FAIL slide_k1 got %0d exp 100", vmaxs[1][0]); end
    for (int k = 2; k < MF; k++) begin
      n_checks++;
      if (vmaxs[k][0] !== 642) begin n_fail++; $display("FAIL slide_k%0d got %0d exp 642", k, vmaxs[k][0]); end
    end
  endtask
  task automatic test_back_to_back();
    logic signed [DW-1:0] rows [8];
    rows = '{1000, 1, 2, 3, 4, 5, 6, 7};
    do_reset();
    for (int r = 0; r < 8; r++) begin
      row(3, rows[r], 1'b0);
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_out_valid row %0d got %b exp 1", r, out_valid); end
      if (r == 6) begin
        n_checks++;
        if (vmaxs[6][3] !== 1000) begin n_fail++; $display("FAIL evict_full_k6 got %0d exp 1000", vmaxs[6][3]); end
        n_checks++;
        if (vmaxs[5][3] !== 6) begin n_fail++; $display("FAIL evict_full_k5 got %0d exp 6", vmaxs[5][3]); end
      end
    end
    n_checks++;
    if (vmaxs[6][3] !== 7) begin n_fail++; $display("FAIL evict_k6 got %0d exp 7", vmaxs[6][3]); end
    n_checks++;
    if (vmaxs[0][3] !== 7) begin n_fail++; $display("FAIL evict_k0 got %0d exp 7", vmaxs[0][3]); end
  endtask
  task automatic test_negative();
    do_reset();
    row(5, MINV, 1'b0);
    n_checks++;
    if (vmaxs[6][5] !== MINV) begin n_fail++; $display("FAIL neg_min_k6 got %0d exp %0d", vmaxs[6][5], MINV); end
    row(5, -1, 1'b0);
    n_checks++;
    if (vmaxs[0][5] !== -1) begin n_fail++; $display("FAIL neg_k0 got %0d exp -1", vmaxs[0][5]); end
    n_checks++;
    if (vmaxs[1][5] !== -1) begin n_fail++; $display("FAIL neg_k1 got %0d exp -1", vmaxs[1][5]); end
    n_checks++;
    if (vmaxs[1][4] !== 0) begin n_fail++; $display("FAIL neg_other_lane got %0d exp 0", vmaxs[1][4]); end
  endtask
  task automatic test_gaps_clear();
    do_reset();
    row(0, 10, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL gap_out_valid got %b exp 0", out_valid); end
    n_checks++;
    if (vmaxs[0][0] !== 10) begin n_fail++; $display("FAIL gap_hold got %0d exp 10", vmaxs[0][0]); end
    row(0, 5, 1'b0);
    n_checks++;
    if (vmaxs[0][0] !== 5) begin n_fail++; $display("FAIL gap_k0 got %0d exp 5", vmaxs[0][0]); end
    n_checks++;
    if (vmaxs[1][0] !== 10) begin n_fail++; $display("FAIL gap_k1 got %0d exp 10", vmaxs[1][0]); end
    cyc(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (vmaxs[1][0] !== 10 || out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_hold got %0d/%b exp 10/0", vmaxs[1][0], out_valid); end
    row(0, 3, 1'b0);
    n_checks++;
    if (vmaxs[6][0] !== 3) begin n_fail++; $display("FAIL clear_alone_k6 got %0d exp 3", vmaxs[6][0]); end
    row(0, 900, 1'b0);
    row(0, 900, 1'b0);
    row(0, 50, 1'b1);
    for (int k = 0; k < MF; k++) begin
      n_checks++;
      if (vmaxs[k][0] !== 50) begin n_fail++; $display("FAIL clear_valid_k%0d got %0d exp 50", k, vmaxs[k][0]); end
    end
    row(0, 40, 1'b0);
    n_checks++;
    if (vmaxs[0][0] !== 40) begin n_fail++; $display("FAIL post_clear_k0 got %0d exp 40", vmaxs[0][0]); end
    n_checks++;
    if (vmaxs[6][0] !== 50) begin n_fail++; $display("FAIL post_clear_k6 got %0d exp 50", vmaxs[6][0]); end
  endtask
  task automatic test_midstream_reset();
    do_reset();
    row(0, 500, 1'b0);
    row(0, 600, 1'b0);
    for (int i = 0; i < SL; i++) hmax[i] = 700;
    cyc(1'b1, 1'b1, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %b exp 0", out_valid); end
    for (int k = 0; k < MF; k++) begin
      n_checks++;
      if (vmaxs[k][0] !== 0) begin n_fail++; $display("FAIL midrst_k%0d got %0d exp 0", k, vmaxs[k][0]); end
    end
    row(0, 20, 1'b0);
    n_checks++;
    if (vmaxs[6][0] !== 20 || out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_next got %0d/%b exp 20/1", vmaxs[6][0], out_valid); end
  endtask
  initial begin
    for (int i = 0; i < SL; i++) hmax[i] = '0;
    @(negedge clk);
    test_reset();
    test_sliding();
    test_back_to_back();
    test_negative();
    test_gaps_clear();
    test_midstream_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
